// File: rtl/mult_issue.sv
// Issue stage for the sequential multiplier: buffers operand pairs, launches one
// multiply at a time and holds each product on a valid/ready result port.
module mult_issue #(
  parameter int DEPTH    = 4,
  parameter int MIN_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  output logic        mult_start,
  input  logic [63:0] mult_product,
  input  logic        mult_done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_product,
  output logic        busy,
  output logic [15:0] op_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (MIN_WAIT > 1) ? $clog2(MIN_WAIT) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [AW:0]   count_q;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [31:0]   multA_q, multA_d, multB_q, multB_d;
  logic          start_q, start_d;
  logic          outValid_q, outValid_d;
  logic [63:0]   outProduct_q, outProduct_d;
  logic [15:0]   opCount_q;
  logic          push, pop, capture, retire;

  assign in_ready = (count_q < FULL_CNT);
  assign push     = in_valid && in_ready;
  assign retire   = outValid_q && out_ready;

  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= {in_a, in_b};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + AW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // The done seen in the first MIN_WAIT-1 cycles after start may still belong to
  // the previous operation, so the wait counter masks it.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    multA_d = multA_q;
    multB_d = multB_q;
    start_d = 1'b0;
    pop     = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop                = 1'b1;
          {multA_d, multB_d} = mem_q[rdPtr_q];
          start_d            = 1'b1;
          state_d            = START;
        end
      end
      START: begin
        wait_d  = CW'(MIN_WAIT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (wait_q != '0) begin
          wait_d = wait_q - CW'(1);
        end else if (mult_done) begin
          if (!outValid_q || out_ready) begin
            capture = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (retire) begin
          capture = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    outProduct_d = capture ? mult_product : outProduct_q;
    outValid_d   = capture ? 1'b1 : (retire ? 1'b0 : outValid_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      wait_q       <= '0;
      multA_q      <= '0;
      multB_q      <= '0;
      start_q      <= 1'b0;
      outValid_q   <= 1'b0;
      outProduct_q <= '0;
      opCount_q    <= '0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      multA_q      <= multA_d;
      multB_q      <= multB_d;
      start_q      <= start_d;
      outValid_q   <= outValid_d;
      outProduct_q <= outProduct_d;
      if (retire) opCount_q <= opCount_q + 16'd1;
    end
  end

  assign mult_a      = multA_q;
  assign mult_b      = multB_q;
  assign mult_start  = start_q;
  assign out_valid   = outValid_q;
  assign out_product = outProduct_q;
  assign busy        = (state_q != IDLE);
  assign op_count    = opCount_q;

endmodule

// File: tb/tb_mult_issue.sv
// Bench for mult_issue: a behavioural multiplier with stall and stale-done modes,
// and a scoreboard of products queued on input acceptance.
module tb_mult_issue;

  localparam int DEPTH    = 4;
  localparam int MIN_WAIT = 2;
  localparam int LAT      = 3;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic [31:0] mult_a, mult_b;
  logic        mult_start;
  logic [63:0] mult_product;
  logic        mult_done;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_product;
  logic        busy;
  logic [15:0] op_count;

  mult_issue #(.DEPTH(DEPTH), .MIN_WAIT(MIN_WAIT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mult_a(mult_a), .mult_b(mult_b), .mult_start(mult_start),
    .mult_product(mult_product), .mult_done(mult_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
    .busy(busy), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Multiplier model: product appears LAT cycles after start; done stays high
  // until the next start (or MIN_WAIT-1 cycles beyond it in stale mode).
  logic [31:0] modelA, modelB;
  logic        modelBusy;
  int          modelCnt, staleCnt;
  logic        stall, staleMode;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mult_done    <= 1'b0;
      mult_product <= '0;
      modelBusy    <= 1'b0;
      modelCnt     <= 0;
      staleCnt     <= 0;
      modelA       <= '0;
      modelB       <= '0;
    end else if (mult_start) begin
      modelA    <= mult_a;
      modelB    <= mult_b;
      modelBusy <= 1'b1;
      modelCnt  <= LAT;
      if (staleMode) staleCnt <= MIN_WAIT - 1;
      else mult_done <= 1'b0;
    end else begin
      if (staleCnt != 0) begin
        staleCnt <= staleCnt - 1;
        if (staleCnt == 1) mult_done <= 1'b0;
      end
      if (modelBusy && !stall) begin
        if (modelCnt <= 1) begin
          mult_done    <= 1'b1;
          mult_product <= {32'b0, modelA} * {32'b0, modelB};
          modelBusy    <= 1'b0;
        end else begin
          modelCnt <= modelCnt - 1;
        end
      end
    end
  end

  logic [63:0] expQ[$];
  int acceptCount = 0;
  int startCount  = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (in_valid && in_ready) begin
        expQ.push_back({32'b0, in_a} * {32'b0, in_b});
        acceptCount++;
      end
      if (mult_start) startCount++;
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) checkOutput("sbEmpty", 64'(expQ.size()), 64'd1);
        else checkOutput("product", out_product, expQ.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    bit accepted = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1;
        break;
      end
    end
    if (!accepted) checkOutput("pushTimeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic waitOutValid(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1;
        break;
      end
    end
    if (!seen) checkOutput("outValidTimeout", 64'd0, 64'd1);
  endtask

  task automatic waitIdle(input int budget);
    bit done = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (expQ.size() == 0 && !busy && !out_valid) begin
        done = 1;
        break;
      end
    end
    if (!done) checkOutput("drainTimeout", 64'(expQ.size()), 64'd0);
  endtask

  int s0, a0;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    stall     = 1'b0;
    staleMode = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rstInReady", 64'(in_ready), 64'd1);
    checkOutput("rstOutValid", 64'(out_valid), 64'd0);
    checkOutput("rstStart", 64'(mult_start), 64'd0);
    checkOutput("rstOpCount", 64'(op_count), 64'd0);
    checkOutput("rstProduct", out_product, 64'd0);
    checkOutput("rstBusy", 64'(busy), 64'd0);
    checkOutput("rstMultAB", {mult_a, mult_b}, 64'd0);

    // Single operation held until the consumer takes it.
    s0 = startCount;
    applyStimulus(32'd3, 32'd5);
    waitOutValid(100);
    checkOutput("singleProduct", out_product, 64'd15);
    checkOutput("singleStarts", 64'(startCount - s0), 64'd1);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    checkOutput("opCount1", 64'(op_count), 64'd1);

    // Operand extremes.
    out_ready = 1'b1;
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    applyStimulus(32'h0, 32'hDEAD_BEEF);
    waitIdle(300);
    checkOutput("opCount3", 64'(op_count), 64'd3);

    // Back-pressure: second result parks in HOLD, third never starts.
    out_ready = 1'b0;
    s0 = startCount;
    applyStimulus(32'd2, 32'd7);
    applyStimulus(32'd4, 32'd9);
    applyStimulus(32'd10, 32'd10);
    waitOutValid(100);
    checkOutput("bpFirst", out_product, 64'd14);
    repeat (30) @(negedge clk);
    checkOutput("bpHeld", out_product, 64'd14);
    checkOutput("bpStarts", 64'(startCount - s0), 64'd2);
    checkOutput("bpBusyHold", 64'(busy), 64'd1);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    checkOutput("bpSecond", out_product, 64'd36);
    checkOutput("bpSecondValid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    waitIdle(300);
    checkOutput("bpStartsAll", 64'(startCount - s0), 64'd3);
    checkOutput("opCount6", 64'(op_count), 64'd6);

    // FIFO full with a stalled multiplier: one in flight plus DEPTH queued.
    stall     = 1'b1;
    out_ready = 1'b0;
    a0        = acceptCount;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_a     = 32'(i + 1);
      in_b     = 32'(i + 20);
    end
    @(negedge clk);
    checkOutput("fullInReady", 64'(in_ready), 64'd0);
    checkOutput("fullAccepted", 64'(acceptCount - a0), 64'(DEPTH + 1));
    @(posedge clk); #1 in_valid = 1'b0;
    stall     = 1'b0;
    out_ready = 1'b1;
    waitIdle(500);
    checkOutput("opCount11", 64'(op_count), 64'd11);

    // Stale done from the previous operation must not be captured.
    staleMode = 1'b1;
    applyStimulus(32'd6, 32'd7);
    waitIdle(200);
    applyStimulus(32'd8, 32'd9);
    waitIdle(200);
    checkOutput("staleLast", out_product, 64'd72);
    checkOutput("opCount13", 64'(op_count), 64'd13);
    staleMode = 1'b0;

    // Reset in WAIT with two entries queued.
    stall     = 1'b1;
    out_ready = 1'b0;
    applyStimulus(32'd1, 32'd2);
    applyStimulus(32'd3, 32'd4);
    applyStimulus(32'd5, 32'd6);
    repeat (5) @(negedge clk);
    checkOutput("preResetBusy", 64'(busy), 64'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("midRstMultAB", {mult_a, mult_b}, 64'd0);
    checkOutput("midRstStart", 64'(mult_start), 64'd0);
    checkOutput("midRstOutValid", 64'(out_valid), 64'd0);
    checkOutput("midRstProduct", out_product, 64'd0);
    checkOutput("midRstOpCount", 64'(op_count), 64'd0);
    checkOutput("midRstBusy", 64'(busy), 64'd0);
    checkOutput("midRstInReady", 64'(in_ready), 64'd1);
    @(posedge clk); #1 reset = 1'b0;
    expQ.delete();
    stall = 1'b0;
    s0    = startCount;
    repeat (10) @(negedge clk);
    checkOutput("postRstNoStart", 64'(startCount - s0), 64'd0);
    out_ready = 1'b1;
    applyStimulus(32'd11, 32'd13);
    waitIdle(200);
    checkOutput("postRstProduct", out_product, 64'd143);
    checkOutput("postRstOpCount", 64'(op_count), 64'd1);
    checkOutput("sbDrained", 64'(expQ.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
